// File: rtl/usb_fifo_pkg.sv
// Shared defaults and helpers for the USB packet FIFO.
// The pointer width is derived from the entry count so ports and internals agree.
package usb_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 64;

  function automatic int calc_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage for the packet FIFO: one synchronous write port and one asynchronous read port.
// Contents carry no reset; the top masks read data whenever nothing is committed.
module fifo_mem
  import usb_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = calc_aw(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_packet_fifo.sv
// Packet FIFO with a commit pointer: written words stay invisible to the reader
// until committed, and can be rolled back as a whole with discard.
module usb_packet_fifo
  import usb_fifo_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int AW     = calc_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  input  logic              discard,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       occupancy,
  output logic [AW:0]       total_count,
  output logic              overflow,
  output logic              underflow
);

  // Handshake: a write is taken when wr_en is high and there is room (or a read
  // frees a slot the same edge); a read is taken when rd_en is high and a
  // committed word exists. Requests that are not taken change nothing but the
  // sticky overflow/underflow flags.
  logic [AW:0]       rptr, cptr, wptr;
  logic [AW:0]       rptr_next, cptr_next, wptr_next;
  logic              rd_acc, wr_acc;
  logic              ovf_set, unf_set;
  logic [DATA_W-1:0] mem_rdata;

  assign occupancy   = cptr - rptr;
  assign total_count = wptr - rptr;
  assign empty       = (cptr == rptr);
  assign full        = (total_count == (AW+1)'(DEPTH));

  assign rd_acc  = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_acc) && !discard && !clear;
  assign ovf_set = wr_en && full && !rd_acc && !discard;
  assign unf_set = rd_en && empty;

  always_comb begin
    rptr_next = rptr + (AW+1)'(rd_acc);
    wptr_next = wptr + (AW+1)'(wr_acc);
    cptr_next = cptr;
    // Discard beats commit: uncommitted words vanish and the commit point holds.
    if (discard) begin
      wptr_next = cptr;
    end else if (commit) begin
      cptr_next = wptr_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rptr      <= '0;
      cptr      <= '0;
      wptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      rptr      <= '0;
      cptr      <= '0;
      wptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rptr      <= rptr_next;
      cptr      <= cptr_next;
      wptr      <= wptr_next;
      overflow  <= overflow  | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign rd_data = empty ? '0 : mem_rdata;

endmodule
